// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register file constants and dump sequencer state type
// Shared by the register file, the CPU datapath and rf_dump_reader.
package rf_pkg;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_BITS = 2;
  localparam int NUM_REGS  = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } rf_dump_state_t;

endpackage

// File: rtl/rf_next_index.sv
// rtl/rf_next_index.sv - lowest set mask bit at/above a starting index
// Ports:
//   mask_i       register select mask
//   from_idx_i   index the search starts from
//   inclusive_i  1: search idx >= from_idx_i, 0: search idx > from_idx_i
//   found_o      a matching set bit exists
//   idx_o        lowest matching index (0 when nothing found)
module rf_next_index #(
  parameter int ADDR_BITS = 2
) (
  input  logic [(1<<ADDR_BITS)-1:0] mask_i,
  input  logic [ADDR_BITS-1:0]      from_idx_i,
  input  logic                      inclusive_i,
  output logic                      found_o,
  output logic [ADDR_BITS-1:0]      idx_o
);

  import rf_pkg::*;

  localparam int N_REGS = 1 << ADDR_BITS;

  // Scan from the top down so the last hit written is the lowest index.
  // The scan never wraps past N_REGS-1.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (mask_i[i] && ((i > int'(from_idx_i)) || (inclusive_i && (i == int'(from_idx_i))))) begin
        found_o = 1'b1;
        idx_o   = ADDR_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/rf_dump_reader.sv
// rtl/rf_dump_reader.sv - mask-driven register file dump sequencer
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   start_i, mask_i     dump request and register select (sampled in IDLE)
//   busy_o              dump in progress (FETCH or SEND)
//   rf_addr_o/rf_data_i combinational register file read port
//   out_valid_o/out_ready_i/out_data_o/out_addr_o/out_last_o  beat stream
//   done_o              one-cycle pulse when a dump completes
module rf_dump_reader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [(1<<ADDR_BITS)-1:0] mask_i,
  output logic                      busy_o,
  output logic [ADDR_BITS-1:0]      rf_addr_o,
  input  logic [WORD_SIZE-1:0]      rf_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [WORD_SIZE-1:0]      out_data_o,
  output logic [ADDR_BITS-1:0]      out_addr_o,
  output logic                      out_last_o,
  output logic                      done_o
);

  import rf_pkg::*;

  localparam int N_REGS = 1 << ADDR_BITS;

  rf_dump_state_t        state_q;
  logic [N_REGS-1:0]     mask_q;
  logic [ADDR_BITS-1:0]  idx_q;
  logic [WORD_SIZE-1:0]  out_data_q;
  logic [ADDR_BITS-1:0]  out_addr_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  done_q;

  logic                  first_found;
  logic [ADDR_BITS-1:0]  first_idx;
  logic                  nxt_found;
  logic [ADDR_BITS-1:0]  nxt_idx;

  // First register of a new dump, searched on the live mask as start is sampled.
  rf_next_index #(.ADDR_BITS(ADDR_BITS)) u_first (
    .mask_i      (mask_i),
    .from_idx_i  ('0),
    .inclusive_i (1'b1),
    .found_o     (first_found),
    .idx_o       (first_idx)
  );

  // Next register above the current one; "none found" also marks the last beat.
  rf_next_index #(.ADDR_BITS(ADDR_BITS)) u_next (
    .mask_i      (mask_q),
    .from_idx_i  (idx_q),
    .inclusive_i (1'b0),
    .found_o     (nxt_found),
    .idx_o       (nxt_idx)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mask_q <= mask_i;
            if (!first_found) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= first_idx;
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          // rf_data_i is the pre-edge content; a write on this edge is not seen.
          out_data_q  <= rf_data_i;
          out_addr_q  <= idx_q;
          out_last_q  <= !nxt_found;
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= nxt_idx;
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // idx_q only moves when entering FETCH, so the read address holds otherwise.
  assign rf_addr_o   = idx_q;
  assign busy_o      = (state_q == FETCH) || (state_q == SEND);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;

endmodule
